// File: rtl/operm_pkg.sv
// Shared definitions for the operand-permute k_ctrl token sequencer:
// opcode width, the opcode constants and the sequencer FSM states.
package operm_pkg;

  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] KC_OP8  = 4'd8;
  localparam logic [CTRL_W-1:0] KC_OP9  = 4'd9;
  localparam logic [CTRL_W-1:0] KC_OP13 = 4'd13;
  localparam logic [CTRL_W-1:0] KC_OP14 = 4'd14;
  localparam logic [CTRL_W-1:0] KC_OP15 = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/operm_kp_seq_if.sv
// Configuration, command and token-handshake bundle of the k_ctrl sequencer.
// The master drives program/commands and kp_ack; the slave is the sequencer.
interface operm_kp_seq_if #(
  parameter int DEPTH = 16,
  parameter int RPT_W = 8
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                          cfg_we;
  logic [AW-1:0]                 cfg_addr;
  logic [operm_pkg::CTRL_W-1:0]  cfg_ctrl;
  logic [RPT_W-1:0]              cfg_rpt;
  logic [AW:0]                   cfg_len;
  logic [RPT_W-1:0]              cfg_loops;
  logic                          start;
  logic                          abort;
  logic                          kp_req;
  logic                          kp_ack;
  logic [operm_pkg::CTRL_W-1:0]  k_ctrl;
  logic                          busy;
  logic                          done;
  logic                          err;

  modport master (
    output cfg_we, cfg_addr, cfg_ctrl, cfg_rpt, cfg_len, cfg_loops,
    output start, abort, kp_ack,
    input  kp_req, k_ctrl, busy, done, err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_ctrl, cfg_rpt, cfg_len, cfg_loops,
    input  start, abort, kp_ack,
    output kp_req, k_ctrl, busy, done, err
  );
endinterface

// File: rtl/operm_kp_mem.sv
// Program register file: one synchronous write port, one combinational read
// port. Contents are deliberately not reset.
module operm_kp_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int EW    = 12
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [EW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [EW-1:0] rdata_o
);
  logic [EW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/operm_kp_seq.sv
// k_ctrl token sequencer: replays a stored program of {opcode, repeat} entries
// a configurable number of times over a req/ack handshake.
module operm_kp_seq
  import operm_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int RPT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  operm_kp_seq_if.slave     kp
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = CTRL_W + RPT_W;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  state_t            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic [RPT_W-1:0]  loop_cnt_q, loop_cnt_d;
  logic [RPT_W-1:0]  cur_rpt_q, cur_rpt_d;
  logic [AW:0]       len_q, len_d;
  logic [RPT_W-1:0]  loops_q, loops_d;
  logic              kp_req_q, kp_req_d;
  logic [CTRL_W-1:0] k_ctrl_q, k_ctrl_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              mem_we;
  logic [AW-1:0]     rd_addr;
  logic [EW-1:0]     rd_data;
  logic              at_last;
  logic              xfer;
  logic              cmd_err;

  // The read port always looks one entry ahead (next pc, or entry 0 when
  // idle / wrapping), so the current entry's repeat count is kept in cur_rpt_q.
  assign at_last = ({1'b0, pc_q} == (len_q - ONE_L));
  assign rd_addr = (state_q == ST_IDLE || at_last) ? '0 : pc_q + 1'b1;
  assign mem_we  = kp.cfg_we && (state_q == ST_IDLE);
  assign xfer    = kp_req_q && kp.kp_ack;

  operm_kp_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .EW    (EW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (kp.cfg_addr),
    .wdata_i ({kp.cfg_ctrl, kp.cfg_rpt}),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      rpt_cnt_q  <= '0;
      loop_cnt_q <= '0;
      cur_rpt_q  <= '0;
      len_q      <= '0;
      loops_q    <= '0;
      kp_req_q   <= 1'b0;
      k_ctrl_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rpt_cnt_q  <= rpt_cnt_d;
      loop_cnt_q <= loop_cnt_d;
      cur_rpt_q  <= cur_rpt_d;
      len_q      <= len_d;
      loops_q    <= loops_d;
      kp_req_q   <= kp_req_d;
      k_ctrl_q   <= k_ctrl_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rpt_cnt_d  = rpt_cnt_q;
    loop_cnt_d = loop_cnt_q;
    cur_rpt_d  = cur_rpt_q;
    len_d      = len_q;
    loops_d    = loops_q;
    kp_req_d   = kp_req_q;
    k_ctrl_d   = k_ctrl_q;
    done_d     = 1'b0;
    cmd_err    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (kp.start && !kp.abort) begin
          if (kp.cfg_len != '0 && kp.cfg_len <= DEPTH_L) begin
            state_d    = ST_RUN;
            len_d      = kp.cfg_len;
            loops_d    = kp.cfg_loops;
            pc_d       = '0;
            rpt_cnt_d  = '0;
            loop_cnt_d = '0;
            kp_req_d   = 1'b1;
            k_ctrl_d   = rd_data[EW-1:RPT_W];
            cur_rpt_d  = rd_data[RPT_W-1:0];
          end else begin
            cmd_err = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cmd_err = kp.start || kp.cfg_we;
        if (kp.abort) begin
          state_d    = ST_IDLE;
          kp_req_d   = 1'b0;
          pc_d       = '0;
          rpt_cnt_d  = '0;
          loop_cnt_d = '0;
        end else if (xfer) begin
          if (rpt_cnt_q < cur_rpt_q) begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end else if (!at_last || loop_cnt_q < loops_q) begin
            pc_d       = at_last ? '0 : pc_q + 1'b1;
            loop_cnt_d = at_last ? loop_cnt_q + 1'b1 : loop_cnt_q;
            rpt_cnt_d  = '0;
            k_ctrl_d   = rd_data[EW-1:RPT_W];
            cur_rpt_d  = rd_data[RPT_W-1:0];
          end else begin
            state_d    = ST_IDLE;
            kp_req_d   = 1'b0;
            done_d     = 1'b1;
            pc_d       = '0;
            rpt_cnt_d  = '0;
            loop_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A rejected command landing on the final transfer yields to done.
    err_d = cmd_err && !done_d;
  end

  always_comb begin
    kp.kp_req = kp_req_q;
    kp.k_ctrl = k_ctrl_q;
    kp.busy   = (state_q == ST_RUN);
    kp.done   = done_q;
    kp.err    = err_q;
  end
endmodule
